// File: rtl/pid_sequencer.sv
// ---------------------------------------------------------------------------
// pid_sequencer
//
// Purpose:
//   Runs the sampling loop of a temperature controller. A free-running
//   period timer issues ticks. On each tick the sequencer requests one
//   sample from the sensor interface. It then range-checks the sample and
//   pulses the PID datapath with the accepted value. One cycle later it
//   latches the PID result as the actuator command. A sensor that stays
//   silent, or that keeps reporting out-of-window values, drives the
//   actuator to a safe command. The sequencer then holds in FAULT until
//   run is dropped.
//
// Ports:
//   clk           in   1   system clock (the only clock)
//   rst_n         in   1   synchronous, active-low reset
//   run           in   1   level, 1 = sequencing active
//   period        in   16  sample period in clk cycles (values < 8 act as 8)
//   sensor_req    out  1   sample request, high in every REQ cycle
//   sensor_valid  in   1   sensor_data valid this cycle
//   sensor_data   in   16  signed Q8.8 temperature
//   pid_enable    out  1   single-cycle enable pulse to the PID datapath
//   pid_feedback  out  16  registered signed Q8.8 feedback to the PID
//   pid_out       in   16  signed Q8.8 PID result
//   cmd_out       out  16  registered signed Q8.8 actuator command
//   cmd_valid     out  1   one-cycle pulse when cmd_out updates
//   sensor_fault  out  1   sticky fault flag (cleared by run=0)
//   overrun       out  1   sticky: a tick arrived while a sample was busy
//   sample_cnt    out  16  captured-sample counter (PID_SEQ_STATS_EN only)
//
// Configuration:
//   Define PID_SEQ_STATS_EN to add the sample_cnt output and its counter.
//   Without the macro the port and its logic are absent. All other
//   behaviour is identical in both builds.
// ---------------------------------------------------------------------------
module pid_sequencer #(
  parameter int          TIMEOUT   = 255,      // max REQ cycles without a transfer
  parameter logic [15:0] SAFE_CMD  = 16'h0000, // command driven on fault
  parameter int          BAD_LIMIT = 3,        // consecutive bad samples to fault
  parameter logic [15:0] TEMP_MIN  = 16'hEC00, // -20.0, inclusive
  parameter logic [15:0] TEMP_MAX  = 16'h3200  // +50.0, inclusive
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] period,
  output logic        sensor_req,
  input  logic        sensor_valid,
  input  logic [15:0] sensor_data,
  output logic        pid_enable,
  output logic [15:0] pid_feedback,
  input  logic [15:0] pid_out,
  output logic [15:0] cmd_out,
  output logic        cmd_valid,
  output logic        sensor_fault,
  output logic        overrun
`ifdef PID_SEQ_STATS_EN
  ,
  output logic [15:0] sample_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQ,
    ENABLE,
    CAPTURE,
    FAULT
  } state_t;

  state_t      state;
  logic [15:0] timer;     // period down-counter
  logic [15:0] wait_cnt;  // REQ cycles already spent without a transfer
  logic [7:0]  bad_cnt;   // consecutive out-of-range samples

  // -------------------------------------------------------------------------
  // Decode of the current cycle
  // -------------------------------------------------------------------------
  logic [15:0] reload;
  logic        tick;
  logic        busy;
  logic        in_range;
  logic [7:0]  bad_next;
  logic        bad_hit;
  logic        wait_done;
  logic        to_fault;

  // NOTE: every signal gets a default at the top of the block so no path
  // can leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    reload    = ((period < 16'd8) ? 16'd8 : period) - 16'd1;
    // The timer only produces ticks once sequencing has left IDLE. A tick
    // in FAULT is harmless because FAULT ignores it.
    tick      = (state != IDLE) && (timer == 16'd0);
    busy      = (state == REQ) || (state == ENABLE) || (state == CAPTURE);
    // Both bounds are inclusive, and the window compare is signed Q8.8.
    in_range  = ($signed(sensor_data) >= $signed(TEMP_MIN)) &&
                ($signed(sensor_data) <= $signed(TEMP_MAX));
    bad_next  = bad_cnt + 8'd1;
    bad_hit   = (bad_next >= 8'(BAD_LIMIT));
    // wait_cnt counts completed REQ cycles. When it reaches TIMEOUT-1, the
    // current cycle is the last one permitted.
    wait_done = (wait_cnt >= 16'(TIMEOUT - 1));
    // A transfer on the last permitted cycle is judged on its data, so it
    // wins over the timeout.
    to_fault  = (state == REQ) &&
                (sensor_valid ? (!in_range && bad_hit) : wait_done);
  end

  // -------------------------------------------------------------------------
  // Period timer: reloads on zero and runs only while run=1.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together at the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= 16'd0;
    end else if (!run) begin
      timer <= 16'd0;
    end else if (state == IDLE || tick) begin
      timer <= reload;
    end else begin
      timer <= timer - 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // Each strobe is written for the cycle the FSM enters:
  //   sensor_req  is high throughout REQ,
  //   pid_enable  is high in ENABLE,
  //   cmd_valid   is high in CAPTURE and in the first FAULT cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 16'd0;
      bad_cnt      <= 8'd0;
      sensor_req   <= 1'b0;
      pid_enable   <= 1'b0;
      pid_feedback <= 16'd0;
      cmd_out      <= SAFE_CMD;
      cmd_valid    <= 1'b0;
      sensor_fault <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // Strobes default low; the case below raises them where needed.
      sensor_req <= 1'b0;
      pid_enable <= 1'b0;
      cmd_valid  <= 1'b0;

      if (!run) begin
        // Abort from any state. cmd_out and pid_feedback keep their values.
        state        <= IDLE;
        wait_cnt     <= 16'd0;
        bad_cnt      <= 8'd0;
        sensor_fault <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        // A tick during a sample in flight is dropped, not queued.
        if (tick && busy) begin
          overrun <= 1'b1;
        end

        unique case (state)
          IDLE: begin
            state <= WAIT_TICK;
          end

          WAIT_TICK: begin
            if (tick) begin
              state      <= REQ;
              sensor_req <= 1'b1;
              wait_cnt   <= 16'd0;
            end
          end

          REQ: begin
            if (to_fault) begin
              state        <= FAULT;
              sensor_fault <= 1'b1;
              cmd_out      <= SAFE_CMD;
              cmd_valid    <= 1'b1;
              if (sensor_valid) begin
                bad_cnt <= bad_next;
              end
            end else if (sensor_valid && in_range) begin
              state        <= ENABLE;
              pid_feedback <= sensor_data;
              pid_enable   <= 1'b1;
              bad_cnt      <= 8'd0;
            end else if (sensor_valid) begin
              // Out-of-window sample, still below the limit: skip this
              // period and keep the previous feedback.
              state   <= WAIT_TICK;
              bad_cnt <= bad_next;
            end else begin
              sensor_req <= 1'b1;
              wait_cnt   <= wait_cnt + 16'd1;
            end
          end

          ENABLE: begin
            // The PID sees pid_enable during this cycle. Its result is
            // latched here, so cmd_valid follows the transfer by 2 cycles.
            state     <= CAPTURE;
            cmd_out   <= pid_out;
            cmd_valid <= 1'b1;
          end

          CAPTURE: begin
            state <= WAIT_TICK;
          end

          FAULT: begin
            // Held until run drops.
            state <= FAULT;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PID_SEQ_STATS_EN
  // -------------------------------------------------------------------------
  // Optional statistics: counts capture pulses and wraps at 16 bits. A
  // fault pulse is not counted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      sample_cnt <= 16'd0;
    end else if (state == CAPTURE && cmd_valid) begin
      sample_cnt <= sample_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pid_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pid_sequencer
//
// Purpose:
//   Directed, self-checking bench for pid_sequencer. Expected values are
//   computed by hand from the sequencer's timing:
//   - 9 cycles from run=1 to the first request,
//   - 8 cycles between requests,
//   - pid_enable 1 cycle after a transfer,
//   - cmd_valid 2 cycles after a transfer.
//   Inputs change on the falling edge and outputs are sampled there.
//
// Ports: none (top-level bench). Define PID_SEQ_STATS_EN for both the
//   bench and the RTL to also exercise sample_cnt.
// ---------------------------------------------------------------------------
module tb_pid_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] period;
  logic        sensor_req;
  logic        sensor_valid;
  logic [15:0] sensor_data;
  logic        pid_enable;
  logic [15:0] pid_feedback;
  logic [15:0] pid_out;
  logic [15:0] cmd_out;
  logic        cmd_valid;
  logic        sensor_fault;
  logic        overrun;
`ifdef PID_SEQ_STATS_EN
  logic [15:0] sample_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;  // rising edges seen so far
  int en_cnt = 0;  // pid_enable pulses seen so far
  int cv_cnt = 0;  // cmd_valid pulses seen so far

  pid_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .period       (period),
    .sensor_req   (sensor_req),
    .sensor_valid (sensor_valid),
    .sensor_data  (sensor_data),
    .pid_enable   (pid_enable),
    .pid_feedback (pid_feedback),
    .pid_out      (pid_out),
    .cmd_out      (cmd_out),
    .cmd_valid    (cmd_valid),
    .sensor_fault (sensor_fault),
    .overrun      (overrun)
`ifdef PID_SEQ_STATS_EN
    ,
    .sample_cnt   (sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pulse monitors. At the rising edge they see the value the previous
  // cycle held.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pid_enable) en_cnt <= en_cnt + 1;
    if (cmd_valid)  cv_cnt <= cv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits, bounded, for sensor_req to go high and returns the cycle it
  // was first seen.
  task automatic wait_req(output int rise);
    int n = 0;
    while (sensor_req !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, sensor_req}, 32'd1);
    rise = cyc;
  endtask

  // Serves one request. Data is presented in the delay-th REQ cycle.
  // Returns at the falling edge after the transfer.
  task automatic do_sample(input int delay, input logic [15:0] data,
                           output int rise);
    wait_req(rise);
    repeat (delay - 1) @(negedge clk);
    sensor_valid = 1'b1;
    sensor_data  = data;
    @(negedge clk);
    sensor_valid = 1'b0;
  endtask

  logic [15:0] bad_data [10] = '{16'h3300, 16'h3300, 16'h1000, 16'h3201, 16'hEBFF,
                                 16'h3200, 16'hEC00, 16'h3300, 16'h8000, 16'h3300};
  logic        bad_good [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int c0, r, rp, n, en0, cv0;
    logic [15:0] fb_exp;

    rst_n = 1'b0; run = 1'b0; period = 16'd8;
    sensor_valid = 1'b0; sensor_data = 16'd0; pid_out = 16'd0;
    step(3);

    // ---------------- reset state ----------------
    check("rst_req",   {31'b0, sensor_req},   32'd0);
    check("rst_en",    {31'b0, pid_enable},   32'd0);
    check("rst_fb",    {16'b0, pid_feedback}, 32'h0);
    check("rst_cmd",   {16'b0, cmd_out},      32'h0);
    check("rst_cv",    {31'b0, cmd_valid},    32'd0);
    check("rst_fault", {31'b0, sensor_fault}, 32'd0);
    check("rst_ovr",   {31'b0, overrun},      32'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_req", {31'b0, sensor_req}, 32'd0);

    // ---------------- normal sampling, period 8 ----------------
    period = 16'd8;
    en0 = en_cnt;
    c0  = cyc;
    run = 1'b1;
    rp  = 0;
    for (int i = 0; i < 3; i++) begin
      pid_out = 16'h0111 * 16'(i + 1);
      do_sample(1, 16'h0400, r);
      if (i == 0) check("first_lat", r - c0, 32'd9);
      else        check("spacing8", r - rp, 32'd8);
      rp = r;
      check("xfer_en",    {31'b0, pid_enable},   32'd1);
      check("xfer_fb",    {16'b0, pid_feedback}, 32'h0400);
      check("xfer_req",   {31'b0, sensor_req},   32'd0);
      check("xfer_cv",    {31'b0, cmd_valid},    32'd0);
      step(1);
      check("cap_cv",     {31'b0, cmd_valid},    32'd1);
      check("cap_cmd",    {16'b0, cmd_out},      {16'b0, pid_out});
      check("cap_en",     {31'b0, pid_enable},   32'd0);
      step(1);
      check("cap_cv_off", {31'b0, cmd_valid},    32'd0);
    end
    check("en_count3", en_cnt - en0, 32'd3);
    check("no_ovr",    {31'b0, overrun}, 32'd0);

    // ---------------- period below 8 behaves as 8 ----------------
    run = 1'b0;
    step(1);
    check("stop_req", {31'b0, sensor_req}, 32'd0);
    period = 16'd3;
    c0  = cyc;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_sample(1, 16'h0400, r);
      if (i == 0) check("p3_first_lat", r - c0, 32'd9);
      else        check("p3_spacing", r - rp, 32'd8);
      rp = r;
      step(2);
    end

    // ---------------- overrun: late sensor ----------------
    check("pre_ovr", {31'b0, overrun}, 32'd0);
    do_sample(10, 16'h0400, r);
    check("ovr_spacing", r - rp, 32'd8);
    check("ovr_set",     {31'b0, overrun},    32'd1);
    check("ovr_en",      {31'b0, pid_enable}, 32'd1);
    rp = r;
    step(2);
    do_sample(1, 16'h0400, r);
    check("ovr_dropped", r - rp, 32'd16);
    check("ovr_sticky",  {31'b0, overrun}, 32'd1);
    step(2);

    // ---------------- range check and bad-sample fault ----------------
    run = 1'b0;
    step(1);
    check("ovr_clear", {31'b0, overrun}, 32'd0);
    period  = 16'd8;
    pid_out = 16'h0AAA;
    fb_exp  = 16'h0400;
    en0 = en_cnt;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) cv0 = cv_cnt;
      do_sample(1, bad_data[i], r);
      if (bad_good[i]) begin
        fb_exp = bad_data[i];
        check("good_en", {31'b0, pid_enable},   32'd1);
        check("good_fb", {16'b0, pid_feedback}, {16'b0, fb_exp});
        step(2);
      end else begin
        check("bad_en",    {31'b0, pid_enable},   32'd0);
        check("bad_fb",    {16'b0, pid_feedback}, {16'b0, fb_exp});
        check("bad_fault", {31'b0, sensor_fault}, (i == 9) ? 32'd1 : 32'd0);
      end
    end
    check("flt_cv",  {31'b0, cmd_valid}, 32'd1);
    check("flt_cmd", {16'b0, cmd_out},   32'h0);
    step(40);
    check("flt_en_total", en_cnt - en0, 32'd3);
    check("flt_one_cv",   cv_cnt - cv0, 32'd1);
    check("flt_hold",     {31'b0, sensor_fault}, 32'd1);
    check("flt_no_req",   {31'b0, sensor_req},   32'd0);

    // ---------------- timeout fault ----------------
    run = 1'b0;
    step(1);
    check("flt_clear", {31'b0, sensor_fault}, 32'd0);
    pid_out = 16'h5555;
    run = 1'b1;
    do_sample(1, 16'h1000, r);
    step(2);
    check("pre_to_cmd", {16'b0, cmd_out}, 32'h5555);
    wait_req(r);
    n = 0;
    while (sensor_req === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("to_req_len", n, 32'd255);
    check("to_fault",   {31'b0, sensor_fault}, 32'd1);
    check("to_cv",      {31'b0, cmd_valid},    32'd1);
    check("to_cmd",     {16'b0, cmd_out},      32'h0);
    en0 = en_cnt;
    step(30);
    check("to_no_en", en_cnt - en0, 32'd0);
    run = 1'b0;
    step(1);
    pid_out = 16'h7777;
    run = 1'b1;
    do_sample(1, 16'h0400, r);
    check("restart_en", {31'b0, pid_enable}, 32'd1);
    step(1);
    check("restart_cmd", {16'b0, cmd_out}, 32'h7777);
    step(1);

    // ---------------- run=0 during REQ with valid ----------------
    wait_req(r);
    en0 = en_cnt;
    run = 1'b0;
    sensor_valid = 1'b1;
    sensor_data  = 16'h1000;
    @(negedge clk);
    sensor_valid = 1'b0;
    check("abort_req", {31'b0, sensor_req},   32'd0);
    check("abort_en",  {31'b0, pid_enable},   32'd0);
    check("abort_cv",  {31'b0, cmd_valid},    32'd0);
    check("abort_cmd", {16'b0, cmd_out},      32'h7777);
    check("abort_fb",  {16'b0, pid_feedback}, 32'h0400);
    step(3);
    check("abort_no_en", en_cnt - en0, 32'd0);

    // ---------------- reset in the middle of a handshake ----------------
    run = 1'b1;
    wait_req(r);
    cv0 = cv_cnt;
    rst_n = 1'b0;
    sensor_valid = 1'b1;
    sensor_data  = 16'h0800;
    @(negedge clk);
    sensor_valid = 1'b0;
    rst_n = 1'b1;
    check("mid_rst_req", {31'b0, sensor_req},   32'd0);
    check("mid_rst_cmd", {16'b0, cmd_out},      32'h0);
    check("mid_rst_fb",  {16'b0, pid_feedback}, 32'h0);
    step(3);
    check("mid_rst_no_cv", cv_cnt - cv0, 32'd0);
    run = 1'b0;
    step(1);

`ifdef PID_SEQ_STATS_EN
    // ---------------- statistics counter ----------------
    check("stats_zero", {16'b0, sample_cnt}, 32'd0);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_sample(1, 16'h0400, r);
      step(2);
    end
    step(1);
    check("stats_five", {16'b0, sample_cnt}, 32'd5);
    run = 1'b0;
    step(1);
    check("stats_clear", {16'b0, sample_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
